// File: rtl/ula_ctrl_fsm.sv
// ula_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit that decodes instructions for the ULA.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: illegal instructions set err and halt instead of running as NOP.
module ula_ctrl_fsm #(
  parameter int         MEM_WAIT_MAX = 255,
  parameter logic [5:0] OP_HALT      = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_req,
  input  logic        uf,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [4:0]  aluop,
  output logic [4:0]  smt,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic        reg_dst_rd,
  output logic        wb_mem,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        err
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam bit         WAIT_EN   = (MEM_WAIT_MAX > 0);
  localparam logic [7:0] WAIT_LAST = (MEM_WAIT_MAX > 0) ? 8'(MEM_WAIT_MAX - 1) : 8'd0;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_LW, C_SW, C_BR, C_J, C_HALT, C_ILL} cls_t;

  state_t      state_reg, state_next;
  cls_t        cls_reg, dec_cls;
  logic [4:0]  aluop_reg, dec_aluop;
  logic [4:0]  smt_reg;
  logic        imm_reg, dec_imm;
  logic        rd_reg, dec_rd;
  logic [7:0]  wait_cnt_reg;
  logic        run_reg;
  logic        err_reg;
  logic        err_set;
  logic        fetch_take;
  logic        mem_timeout;

  // IR[25:11] (register numbers) are consumed by the external datapath only.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:11];

  // run_reg keeps instr_req low until the first clock after reset.
  assign fetch_take  = (state_reg == S_FETCH) && run_reg && instr_valid;
  assign mem_timeout = WAIT_EN && (wait_cnt_reg == WAIT_LAST);

  always_comb begin
    dec_cls   = C_ILL;
    dec_aluop = 5'b00000;
    dec_imm   = 1'b0;
    dec_rd    = 1'b0;
    case (instr[31:26])
      6'h00: begin
        dec_cls = C_ALU;
        dec_rd  = 1'b1;
        case (instr[5:0])
          6'h20:   dec_aluop = 5'b00001;
          6'h22:   dec_aluop = 5'b00010;
          6'h24:   dec_aluop = 5'b00011;
          6'h25:   dec_aluop = 5'b00100;
          6'h27:   dec_aluop = 5'b00101;
          6'h26:   dec_aluop = 5'b00110;
          6'h00:   dec_aluop = 5'b00111;
          6'h02:   dec_aluop = 5'b01000;
          default: begin
            dec_cls = C_ILL;
            dec_rd  = 1'b0;
          end
        endcase
      end
      6'h08: begin dec_cls = C_ALU; dec_aluop = 5'b00001; dec_imm = 1'b1; end
      6'h23: begin dec_cls = C_LW;  dec_aluop = 5'b00001; dec_imm = 1'b1; end
      6'h2B: begin dec_cls = C_SW;  dec_aluop = 5'b00001; dec_imm = 1'b1; end
      6'h04: begin dec_cls = C_BR;  dec_aluop = 5'b01011; end
      6'h05: begin dec_cls = C_BR;  dec_aluop = 5'b01100; end
      6'h06: begin dec_cls = C_BR;  dec_aluop = 5'b01001; end
      6'h02: dec_cls = C_J;
      default: dec_cls = C_ILL;
    endcase
    if (instr[31:26] == OP_HALT) begin
      dec_cls   = C_HALT;
      dec_aluop = 5'b00000;
      dec_imm   = 1'b0;
      dec_rd    = 1'b0;
    end
    if (dec_cls == C_ILL && !TRAP_EN) begin
      dec_cls   = C_NOP;
      dec_aluop = 5'b00000;
      dec_imm   = 1'b0;
      dec_rd    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      cls_reg      <= C_NOP;
      aluop_reg    <= 5'b00000;
      smt_reg      <= 5'b00000;
      imm_reg      <= 1'b0;
      rd_reg       <= 1'b0;
      wait_cnt_reg <= 8'd0;
      run_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;
      if (err_set) err_reg <= 1'b1;
      // Decoded fields are latched together with the instruction so they are valid from DECODE on.
      if (fetch_take) begin
        cls_reg   <= dec_cls;
        aluop_reg <= dec_aluop;
        smt_reg   <= instr[10:6];
        imm_reg   <= dec_imm;
        rd_reg    <= dec_rd;
      end
      if (state_reg != S_MEM) wait_cnt_reg <= 8'd0;
      else if (wait_cnt_reg != 8'hFF) wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    instr_req  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    wb_mem     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    err_set    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        instr_req = run_reg;
        if (fetch_take) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (cls_reg)
          C_HALT:  state_next = S_HALT;
          C_ILL: begin
            err_set    = 1'b1;
            state_next = S_HALT;
          end
          default: state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_reg)
          C_BR: begin
            pc_we      = 1'b1;
            pc_sel     = {1'b0, uf};
            state_next = S_FETCH;
          end
          C_J: begin
            pc_we      = 1'b1;
            pc_sel     = 2'b10;
            state_next = S_FETCH;
          end
          C_LW, C_SW: state_next = S_MEM;
          C_ALU:      state_next = S_WB;
          default: begin
            pc_we      = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_reg == C_SW);
        // An ack arriving in the timeout cycle takes priority over the timeout.
        if (mem_ack) begin
          if (cls_reg == C_LW) begin
            state_next = S_WB;
          end else begin
            pc_we      = 1'b1;
            state_next = S_FETCH;
          end
        end else if (mem_timeout) begin
          err_set    = 1'b1;
          pc_we      = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        wb_mem     = (cls_reg == C_LW);
        pc_we      = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  assign aluop       = aluop_reg;
  assign smt         = smt_reg;
  assign alu_src_imm = imm_reg;
  assign reg_dst_rd  = rd_reg;
  assign halted      = (state_reg == S_HALT);
  assign err         = err_reg;

endmodule

// File: tb/tb_ula_ctrl_fsm.sv
// tb_ula_ctrl_fsm: randomized self-checking bench for ula_ctrl_fsm against a per-instruction cycle model.
module tb_ula_ctrl_fsm;
  localparam int WMAX = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [5:0] R_FN   [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h00, 6'h02};
  localparam logic [5:0] BR_OP  [3] = '{6'h04, 6'h05, 6'h06};
  localparam logic [4:0] BR_ALU [3] = '{5'b01011, 5'b01100, 5'b01001};

  typedef enum {K_ALU, K_LW, K_SW, K_BR, K_J, K_ILL, K_HALT} kind_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_req;
  logic        uf = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, alu_src_imm, reg_we, reg_dst_rd, wb_mem, pc_we, halted, err;
  logic [4:0]  aluop, smt;
  logic [1:0]  pc_sel;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn = 0;
  logic err_exp = 1'b0;
  logic halt_exp = 1'b0;

  always #5 clk = ~clk;

  ula_ctrl_fsm #(.MEM_WAIT_MAX(WMAX), .OP_HALT(6'h3F)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .instr_req(instr_req),
    .uf(uf), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .aluop(aluop), .smt(smt),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .reg_dst_rd(reg_dst_rd), .wb_mem(wb_mem),
    .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted), .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd1();
    return 1'($urandom);
  endfunction

  function automatic logic [31:0] ctl_obs();
    return {22'd0, instr_req, mem_req, mem_we, reg_we, wb_mem, pc_we, pc_sel, halted, err};
  endfunction

  function automatic logic [31:0] fields_obs();
    return {20'd0, aluop, smt, alu_src_imm, reg_dst_rd};
  endfunction

  function automatic logic [9:0] mk(input logic ir, input logic mr, input logic mw, input logic rw,
                                    input logic wm, input logic pw, input logic [1:0] ps, input logic h);
    return {ir, mr, mw, rw, wm, pw, ps, h, err_exp};
  endfunction

  // Reference decode: table lookups of the instruction set.
  function automatic void classify(input logic [31:0] w, output kind_e k, output logic [4:0] a,
                                   output logic imm, output logic rd);
    logic [5:0] op;
    op = w[31:26];
    k = K_ILL; a = 5'd0; imm = 1'b0; rd = 1'b0;
    if (op == 6'h3F) k = K_HALT;
    else if (op == 6'h00) begin
      for (int i = 0; i < 8; i++)
        if (R_FN[i] == w[5:0]) begin k = K_ALU; a = 5'(i + 1); rd = 1'b1; end
    end
    else if (op == 6'h08) begin k = K_ALU; a = 5'd1; imm = 1'b1; end
    else if (op == 6'h23) begin k = K_LW;  a = 5'd1; imm = 1'b1; end
    else if (op == 6'h2B) begin k = K_SW;  a = 5'd1; imm = 1'b1; end
    else if (op == 6'h02) k = K_J;
    else begin
      for (int i = 0; i < 3; i++)
        if (BR_OP[i] == op) begin k = K_BR; a = BR_ALU[i]; end
    end
  endfunction

  // One clock cycle: drive inputs, compare strobes mid-cycle, advance past the edge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic u, input logic ack,
                     input logic [9:0] exp, input string tag);
    instr_valid = v; instr = ins; uf = u; mem_ack = ack;
    @(negedge clk);
    check_eq(tag, ctl_obs(), {22'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
    #1;
    check_eq("rst_ctl", ctl_obs(), 32'd0);
    check_eq("rst_fields", fields_obs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_release", ctl_obs(), 32'd0);
    @(posedge clk); #1;
    err_exp = 1'b0;
    halt_exp = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] w, input logic u3, input int d, input int pre_wait,
                           input int abort_at);
    kind_e k;
    logic [4:0] ea;
    logic eimm, erd;
    classify(w, k, ea, eimm, erd);
    n_txn++;
    $display("txn %0d: instr=%08h kind=%s uf=%0b ack_wait=%0d", n_txn, w, k.name(), u3, d);
    for (int i = 0; i < pre_wait; i++)
      cyc(1'b0, $urandom, rnd1(), rnd1(), mk(1, 0, 0, 0, 0, 0, 2'b00, 0), "fetch_wait");
    cyc(1'b1, w, rnd1(), rnd1(), mk(1, 0, 0, 0, 0, 0, 2'b00, 0), "fetch");
    cyc(rnd1(), $urandom, rnd1(), rnd1(), mk(0, 0, 0, 0, 0, 0, 2'b00, 0), "decode");
    if (k == K_HALT || (k == K_ILL && TRAP)) begin
      if (k == K_ILL) err_exp = 1'b1;
      for (int i = 0; i < 6; i++)
        cyc(1'b1, $urandom, rnd1(), rnd1(), mk(0, 0, 0, 0, 0, 0, 2'b00, 1), "halt");
      halt_exp = 1'b1;
      return;
    end
    if (k == K_ILL) check_eq("nop_aluop", 32'(aluop), 32'd0);
    else check_eq("fields", fields_obs(), {20'd0, ea, w[10:6], eimm, erd});
    case (k)
      K_BR:    cyc(rnd1(), $urandom, u3, rnd1(), mk(0, 0, 0, 0, 0, 1, {1'b0, u3}, 0), "exec_branch");
      K_J:     cyc(rnd1(), $urandom, rnd1(), rnd1(), mk(0, 0, 0, 0, 0, 1, 2'b10, 0), "exec_jump");
      K_ILL:   cyc(rnd1(), $urandom, rnd1(), rnd1(), mk(0, 0, 0, 0, 0, 1, 2'b00, 0), "exec_nop");
      default: cyc(rnd1(), $urandom, rnd1(), rnd1(), mk(0, 0, 0, 0, 0, 0, 2'b00, 0), "exec");
    endcase
    if (k == K_ALU) begin
      cyc(rnd1(), $urandom, rnd1(), rnd1(), mk(0, 0, 0, 1, 0, 1, 2'b00, 0), "wb");
    end else if (k == K_LW || k == K_SW) begin
      for (int j = 1; j <= WMAX; j++) begin
        logic ack, last;
        logic [9:0] e;
        ack  = (j == d + 1);
        last = ack || (j == WMAX);
        e = mk(0, 1, (k == K_SW), 0, 0, last && (k == K_SW || !ack), 2'b00, 0);
        if (j == abort_at) begin
          instr_valid = rnd1(); mem_ack = 1'b0; uf = rnd1();
          @(negedge clk);
          check_eq("mem_before_abort", ctl_obs(), {22'd0, e});
          #1 rst_n = 1'b0;
          #1 check_eq("async_mem_drop", 32'(mem_req), 32'd0);
          do_reset();
          return;
        end
        cyc(rnd1(), $urandom, rnd1(), ack, e, "mem");
        if (last) begin
          if (!ack) err_exp = 1'b1;
          break;
        end
      end
      if (k == K_LW && d + 1 <= WMAX)
        cyc(rnd1(), $urandom, rnd1(), rnd1(), mk(0, 0, 0, 1, 1, 1, 2'b00, 0), "wb_load");
    end
  endtask

  initial begin
    logic [31:0] w;
    kind_e kk;
    logic [4:0] ka;
    logic ki, kr;
    int sel, d, ab;
    @(posedge clk); #1;
    do_reset();
    // Directed cases
    run_instr({6'h00, 5'd1, 5'd2, 5'd3, 5'd5, 6'h20}, 1'b0, 0, 0, 0);
    run_instr({6'h04, 26'h0000010}, 1'b1, 0, 1, 0);
    run_instr({6'h04, 26'h0000010}, 1'b0, 0, 0, 0);
    run_instr({6'h23, 26'h0001234}, 1'b0, 3, 0, 0);
    run_instr({6'h2B, 26'h0004321}, 1'b0, 9, 0, 0);
    run_instr({6'h11, 26'h0001234}, 1'b0, 0, 0, 0);
    if (halt_exp) do_reset();
    run_instr({6'h00, 20'h12345, 6'h3F}, 1'b0, 0, 0, 0);
    if (halt_exp) do_reset();
    run_instr({6'h23, 26'h0000040}, 1'b0, 9, 0, 2);
    run_instr({6'h3F, 26'h0000000}, 1'b0, 0, 0, 0);
    do_reset();
    // Randomized instruction stream
    for (int t = 0; t < 200; t++) begin
      w   = $urandom;
      sel = $urandom_range(0, 15);
      d   = $urandom_range(0, 5);
      ab  = 0;
      if ($urandom_range(0, 39) == 0) w[31:26] = 6'h3F;
      else if (sel < 8) begin w[31:26] = 6'h00; w[5:0] = R_FN[sel]; end
      else if (sel == 8)  w[31:26] = 6'h08;
      else if (sel == 9)  w[31:26] = 6'h23;
      else if (sel == 10) w[31:26] = 6'h2B;
      else if (sel < 14)  w[31:26] = BR_OP[sel - 11];
      else if (sel == 14) w[31:26] = 6'h02;
      else begin
        do begin
          w = $urandom;
          classify(w, kk, ka, ki, kr);
        end while (kk != K_ILL);
      end
      if ((sel == 9 || sel == 10) && $urandom_range(0, 9) == 0) begin
        d  = 9;
        ab = $urandom_range(1, WMAX);
      end
      run_instr(w, rnd1(), d, $urandom_range(0, 2), ab);
      if (halt_exp) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
